unified_mem_ctrl: RTL and testbench

Unified memory controller for the pipelined CPU: a single-port word RAM of configurable depth shared by instruction fetch and data access, with configurable wait states and RISC-V byte/half/word access types. It replaces the separate zero-latency instruction ROM and data RAM at the computer top level. It presents two req/ready ports to the CPU and a combined stall output the pipeline uses to freeze.

---
 rtl/umc_pkg.sv | 39 +++
 rtl/umc_ram.sv | 25 ++
 rtl/unified_mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_unified_mem_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/umc_pkg.sv
// Shared encodings for the unified memory controller: access types,
// FSM states, port ownership and the alignment helpers.
package umc_pkg;

   localparam logic [2:0] DMT_W  = 3'd0;
   localparam logic [2:0] DMT_HS = 3'd1;
   localparam logic [2:0] DMT_HU = 3'd2;
   localparam logic [2:0] DMT_BS = 3'd3;
   localparam logic [2:0] DMT_BU = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } umc_state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   function automatic logic is_half(input logic [2:0] t);
      return (t == DMT_HS) || (t == DMT_HU);
   endfunction

   function automatic logic is_byte(input logic [2:0] t);
      return (t == DMT_BS) || (t == DMT_BU);
   endfunction

   // Unknown codes fall back to word, so they need word alignment.
   function automatic logic misaligned(input logic [2:0] t,
                                       input logic [1:0] a);
      if (is_byte(t))
         return 1'b0;
      else if (is_half(t))
         return a[0];
      else
         return a != 2'b00;
   endfunction

endpackage

// File: rtl/umc_ram.sv
// Single-port synchronous word RAM with byte enables.
// Contents are never reset.
module umc_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i])
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Shared fetch/data memory controller with wait states and RISC-V access types.
// Define UMC_RR_ARB_EN for round-robin arbitration instead of data priority.
module unified_mem_ctrl
   import umc_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    WAIT_STATES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [2:0]  dm_type,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ready,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        stall
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WS_INIT =
      (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   umc_state_e  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        own_q, own_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [2:0]  type_q, type_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mis_q, mis_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        last_q, last_d;

   logic        grant_dm;
   logic        resp_if, resp_dm;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic [15:0] half_v;
   logic [7:0]  byte_v;
   logic [31:0] load_v;
   logic        unused_bits;

`ifdef UMC_RR_ARB_EN
   assign grant_dm = dm_req & (~if_req | (last_q == OWN_IF));
`else
   assign grant_dm = dm_req;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      own_d   = own_q;
      addr_d  = addr_q;
      type_d  = type_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      mis_d   = mis_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               own_d   = grant_dm ? OWN_DM : OWN_IF;
               last_d  = own_d;
               addr_d  = grant_dm ? dm_addr[AW+1:0] : if_addr[AW+1:0];
               type_d  = grant_dm ? dm_type : DMT_W;
               we_d    = grant_dm & dm_we;
               wdata_d = dm_wdata;
               mis_d   = grant_dm & misaligned(dm_type, dm_addr[1:0]);
               cnt_d   = WS_INIT;
               state_d = (WAIT_STATES > 0) ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 3'd0)
               state_d = ST_RESP;
            else
               cnt_d = cnt_q - 3'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign resp_if = (state_q == ST_RESP) && (own_q == OWN_IF);
   assign resp_dm = (state_q == ST_RESP) && (own_q == OWN_DM);

   // The RAM read is launched from the incoming address while idle so a
   // zero-wait access still has data in the response cycle.
   assign ram_addr = (state_q == ST_IDLE) ? addr_d[AW+1:2] : addr_q[AW+1:2];
   assign ram_we   = resp_dm & we_q & ~mis_q;

   always_comb begin
      ram_be    = 4'b1111;
      ram_wdata = wdata_q;
      if (is_byte(type_q)) begin
         ram_be    = 4'b0001 << addr_q[1:0];
         ram_wdata = {4{wdata_q[7:0]}};
      end else if (is_half(type_q)) begin
         ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
         ram_wdata = {2{wdata_q[15:0]}};
      end
   end

   always_comb begin
      half_v = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      byte_v = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
      case (type_q)
         DMT_HS:  load_v = {{16{half_v[15]}}, half_v};
         DMT_HU:  load_v = {16'h0000, half_v};
         DMT_BS:  load_v = {{24{byte_v[7]}}, byte_v};
         DMT_BU:  load_v = {24'h000000, byte_v};
         default: load_v = ram_rdata;
      endcase
   end

   assign if_rdata_d = resp_if ? ram_rdata : if_rdata_q;
   assign dm_rdata_d = resp_dm ? (mis_q ? 32'h0 : load_v) : dm_rdata_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         own_q      <= OWN_IF;
         addr_q     <= '0;
         type_q     <= DMT_W;
         we_q       <= 1'b0;
         wdata_q    <= 32'h0;
         mis_q      <= 1'b0;
         if_rdata_q <= 32'h0;
         dm_rdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         own_q      <= own_d;
         addr_q     <= addr_d;
         type_q     <= type_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         mis_q      <= mis_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

`ifdef UMC_RR_ARB_EN
   // Fetch counts as last granted after reset, so data wins the first tie.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         last_q <= OWN_IF;
      else
         last_q <= last_d;
   end
`else
   assign last_q = OWN_IF;
`endif

   umc_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (ram_be),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign if_ready = resp_if;
   assign dm_ready = resp_dm;
   assign dm_err   = resp_dm & mis_q;
   assign if_rdata = if_rdata_d;
   assign dm_rdata = dm_rdata_d;
   assign stall    = (if_req & ~if_ready) | (dm_req & ~dm_ready);

   assign unused_bits = ^{if_addr[31:AW+2], dm_addr[31:AW+2], last_d};

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl: a 1-wait-state instance for the
// access/latency/reset checks and a 0-wait-state instance for arbitration.
module tb_unified_mem_ctrl;
   import umc_pkg::*;

   typedef struct {
      logic        dm;
      logic [31:0] data;
      logic        err;
      logic        chkd;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   exp_t q1[$];
   exp_t q0[$];

   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [2:0]  dm_type;
   logic        if_ready, dm_ready, dm_err, stall;
   logic [31:0] if_rdata, dm_rdata;

   logic        z_if_req, z_dm_req, z_dm_we;
   logic [31:0] z_if_addr, z_dm_addr, z_dm_wdata;
   logic [2:0]  z_dm_type;
   logic        z_if_ready, z_dm_ready, z_dm_err, z_stall;
   logic [31:0] z_if_rdata, z_dm_rdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   unified_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr),
      .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .stall(stall)
   );

   unified_mem_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rstn(rstn),
      .if_req(z_if_req), .if_addr(z_if_addr),
      .if_ready(z_if_ready), .if_rdata(z_if_rdata),
      .dm_req(z_dm_req), .dm_we(z_dm_we), .dm_type(z_dm_type),
      .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata),
      .dm_ready(z_dm_ready), .dm_rdata(z_dm_rdata), .dm_err(z_dm_err),
      .stall(z_stall)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
   endtask

   // Monitors: pop and compare whenever a DUT signals a response.
   always @(negedge clk) begin
      exp_t e;
      if (if_ready || dm_ready) begin
         if (q1.size() == 0) begin
            n_checks++;
            $display("FAIL dut1_unexpected: got if_ready=%b dm_ready=%b expected none",
                     if_ready, dm_ready);
         end else begin
            e = q1.pop_front();
            chk("dut1_owner", {31'b0, dm_ready}, {31'b0, e.dm});
            chk("dut1_cycle", cyc, e.cyc);
            if (e.chkd)
               chk("dut1_rdata", e.dm ? dm_rdata : if_rdata, e.data);
            if (e.dm)
               chk("dut1_err", {31'b0, dm_err}, {31'b0, e.err});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (z_if_ready || z_dm_ready) begin
         if (q0.size() == 0) begin
            n_checks++;
            $display("FAIL dut0_unexpected: got if_ready=%b dm_ready=%b expected none",
                     z_if_ready, z_dm_ready);
         end else begin
            e = q0.pop_front();
            chk("dut0_owner", {31'b0, z_dm_ready}, {31'b0, e.dm});
            chk("dut0_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_ready(input logic is_dm, input logic chk_stall);
      int  n = 0;
      logic rdy = 1'b0;
      while (!rdy && n < 20) begin
         @(negedge clk);
         n++;
         rdy = is_dm ? dm_ready : if_ready;
         if (chk_stall)
            chk(rdy ? "stall_at_ready" : "stall_waiting",
                {31'b0, stall}, {31'b0, ~rdy});
      end
      if (!rdy) begin
         n_checks++;
         $display("FAIL timeout: got no ready after %0d cycles expected ready", n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dm_acc(input logic we, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic chkd, input logic [31:0] exp_d,
                         input logic exp_err);
      dm_req = 1'b1; dm_we = we; dm_type = t;
      dm_addr = a; dm_wdata = wd;
      q1.push_back('{dm: 1'b1, data: exp_d, err: exp_err,
                     chkd: chkd, cyc: cyc + 2});
      wait_ready(1'b1, 1'b0);
      dm_req = 1'b0; dm_we = 1'b0;
   endtask

   task automatic if_acc(input logic [31:0] a, input logic [31:0] exp_d);
      if_req = 1'b1; if_addr = a;
      q1.push_back('{dm: 1'b0, data: exp_d, err: 1'b0,
                     chkd: 1'b1, cyc: cyc + 2});
      wait_ready(1'b0, 1'b1);
      if_req = 1'b0;
   endtask

   initial begin
      int c0;
      rstn = 1'b0;
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
      dm_type = DMT_W; dm_addr = 0; dm_wdata = 0;
      z_if_req = 0; z_if_addr = 0; z_dm_req = 0; z_dm_we = 0;
      z_dm_type = DMT_W; z_dm_addr = 0; z_dm_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_ready", {31'b0, if_ready}, 32'h0);
      chk("rst_dm_ready", {31'b0, dm_ready}, 32'h0);
      chk("rst_dm_err", {31'b0, dm_err}, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      dm_acc(1, DMT_W, 32'h0, 32'h00500093, 0, 0, 0);
      if_acc(32'h0, 32'h00500093);
      if_acc(32'h3, 32'h00500093);

      dm_acc(1, DMT_W,  32'h40, 32'hDEADBEEF, 0, 0, 0);
      dm_acc(0, DMT_BS, 32'h43, 0, 1, 32'hFFFFFFDE, 0);
      dm_acc(0, DMT_HU, 32'h40, 0, 1, 32'h0000BEEF, 0);
      dm_acc(0, DMT_HS, 32'h42, 0, 1, 32'hFFFFDEAD, 0);
      dm_acc(0, DMT_BU, 32'h40, 0, 1, 32'h000000EF, 0);
      #1 chk("if_rdata_hold", if_rdata, 32'h00500093);
      dm_acc(1, DMT_BU, 32'h41, 32'h0000005A, 0, 0, 0);
      dm_acc(0, DMT_W,  32'h40, 0, 1, 32'hDEAD5AEF, 0);

      dm_acc(1, DMT_W,  32'h44, 32'h11223344, 0, 0, 0);
      dm_acc(0, DMT_W,  32'h42, 0, 1, 32'h0, 1);
      dm_acc(1, DMT_HU, 32'h45, 32'h0000FFFF, 1, 32'h0, 1);
      dm_acc(0, DMT_W,  32'h44, 0, 1, 32'h11223344, 0);
      dm_acc(1, DMT_HS, 32'h46, 32'h0000ABCD, 0, 0, 0);
      dm_acc(0, DMT_W,  32'h44, 0, 1, 32'hABCD3344, 0);
      dm_acc(0, 3'd7,   32'h44, 0, 1, 32'hABCD3344, 0);

      dm_acc(1, DMT_W, 32'h40 + 32'd4096, 32'h600D0001, 0, 0, 0);
      dm_acc(0, DMT_W, 32'h40, 0, 1, 32'h600D0001, 0);

      // Both ports requesting continuously on the zero-wait instance.
      c0 = cyc;
      z_if_req = 1'b1; z_dm_req = 1'b1; z_dm_addr = 32'h4;
`ifdef UMC_RR_ARB_EN
      q0.push_back('{dm: 1'b1, data: 0, err: 0, chkd: 0, cyc: c0 + 1});
      q0.push_back('{dm: 1'b0, data: 0, err: 0, chkd: 0, cyc: c0 + 3});
      q0.push_back('{dm: 1'b1, data: 0, err: 0, chkd: 0, cyc: c0 + 5});
      q0.push_back('{dm: 1'b0, data: 0, err: 0, chkd: 0, cyc: c0 + 7});
`else
      q0.push_back('{dm: 1'b1, data: 0, err: 0, chkd: 0, cyc: c0 + 1});
      q0.push_back('{dm: 1'b1, data: 0, err: 0, chkd: 0, cyc: c0 + 3});
      q0.push_back('{dm: 1'b1, data: 0, err: 0, chkd: 0, cyc: c0 + 5});
      q0.push_back('{dm: 1'b1, data: 0, err: 0, chkd: 0, cyc: c0 + 7});
`endif
      repeat (8) @(posedge clk);
      #1;
      z_if_req = 1'b0; z_dm_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset lands while a store is still in its wait state.
      dm_req = 1'b1; dm_we = 1'b1; dm_type = DMT_W;
      dm_addr = 32'h44; dm_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("arst_dm_ready", {31'b0, dm_ready}, 32'h0);
      chk("arst_if_ready", {31'b0, if_ready}, 32'h0);
      chk("arst_dm_err", {31'b0, dm_err}, 32'h0);
      chk("arst_if_rdata", if_rdata, 32'h0);
      chk("arst_dm_rdata", dm_rdata, 32'h0);
      dm_req = 1'b0; dm_we = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      dm_acc(0, DMT_W, 32'h44, 0, 1, 32'hABCD3344, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("dut1_queue_empty", q1.size(), 32'h0);
      chk("dut0_queue_empty", q0.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
